// File: rtl/logic_op_pipe_if.sv
// Operand/result bundle for logic_op_pipe: valid/ready operand stream in,
// valid/ready result stream out, plus the completed-transfer counter.
interface logic_op_pipe_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic             out_zero;
  logic             out_par;
  logic             out_err;
  logic [CNT_W-1:0] op_count;

  // master: operand source and result consumer side
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_par, out_err, op_count
  );

  // slave: the pipeline itself
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_par, out_err, op_count
  );
endinterface

// File: rtl/logic_op_pipe.sv
// Two-stage pipelined bitwise logic unit (OR, NOT, NAND, NOR, XOR, XNOR)
// with valid/ready flow control, result flags and a transfer counter.
module logic_op_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  logic_op_pipe_if.slave    bus
);

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_NOT  = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_t;

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [2:0]       s1_op;

  logic             s2_valid;
  logic [W-1:0]     s2_res;
  logic             s2_zero;
  logic             s2_par;
  logic             s2_err;
  logic [CNT_W-1:0] count;

  logic             s1_adv;
  logic             s2_adv;
  logic [W-1:0]     res_d;
  logic             err_d;

  // A stage may advance when it is empty or the stage after it is draining.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_op <= bus.in_op;
      end
    end
  end

  // Reserved opcodes yield an all-zero result flagged as an error.
  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (s1_op)
      OP_OR:   res_d = s1_a | s1_b;
      OP_NOT:  res_d = ~s1_a;
      OP_NAND: res_d = ~(s1_a & s1_b);
      OP_NOR:  res_d = ~(s1_a | s1_b);
      OP_XOR:  res_d = s1_a ^ s1_b;
      OP_XNOR: res_d = ~(s1_a ^ s1_b);
      default: err_d = 1'b1;
    endcase
  end

  // Result registers only load real beats so outputs keep their reset
  // values until the first valid result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_zero  <= 1'b0;
      s2_par   <= 1'b0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res  <= res_d;
        s2_zero <= (res_d == '0);
        s2_par  <= ^res_d;
        s2_err  <= err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (s2_valid && bus.out_ready) begin
      count <= count + 1'b1;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_res   = s2_res;
  assign bus.out_zero  = s2_zero;
  assign bus.out_par   = s2_par;
  assign bus.out_err   = s2_err;
  assign bus.op_count  = count;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Bench for logic_op_pipe: directed vector table, backpressure/reset/wrap
// sequences and a randomized run checked by a queue-based scoreboard.
module tb_logic_op_pipe;
  localparam int W  = 8;
  localparam int NV = 12;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         par;
    logic         err;
  } result_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         zero;
    logic         par;
    logic         err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_op_pipe_if #(.W(W), .CNT_W(16)) bus ();
  logic_op_pipe_if #(.W(W), .CNT_W(2))  bus2 ();

  logic_op_pipe #(.W(W), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic_op_pipe #(.W(W), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // The narrow-counter copy sees exactly the same traffic as the main one.
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_a      = bus.in_a;
  assign bus2.in_b      = bus.in_b;
  assign bus2.in_op     = bus.in_op;
  assign bus2.out_ready = bus.out_ready;

  int total = 0;
  int bad   = 0;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic result_t refModel(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    result_t r;
    case (op)
      3'd0:    r.res = a | b;
      3'd1:    r.res = ~a;
      3'd2:    r.res = ~(a & b);
      3'd3:    r.res = ~(a | b);
      3'd4:    r.res = a ^ b;
      3'd5:    r.res = ~(a ^ b);
      default: r.res = '0;
    endcase
    r.err  = (op > 3'd5);
    r.zero = (r.res == '0);
    r.par  = ($countones(r.res) % 2) == 1;
    return r;
  endfunction

  result_t      expQ[$];
  result_t      front;
  int           modelCount = 0;
  bit           armed = 0;
  bit           hold = 0;
  logic [W-1:0] holdRes;
  logic         holdZero, holdPar, holdErr;

  // Scoreboard: inputs are stable from here to the next rising edge, so
  // the handshakes seen now are exactly the transfers that edge performs.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("op_count", 32'(bus.op_count), 32'(modelCount % 65536));
      checkOutput("op_count_w2", 32'(bus2.op_count), 32'(modelCount % 4));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(!(expQ.size() == 2 && !bus.out_ready)));
      if (hold) begin
        checkOutput("hold_valid", 32'(bus.out_valid), 32'(1));
        checkOutput("hold_res", 32'(bus.out_res), 32'(holdRes));
        checkOutput("hold_flags", 32'({bus.out_zero, bus.out_par, bus.out_err}),
                    32'({holdZero, holdPar, holdErr}));
      end
    end
    hold = 0;
    if (rst) begin
      expQ.delete();
      modelCount = 0;
      armed = 1;
    end else if (armed) begin
      if (bus.out_valid && !bus.out_ready) begin
        hold = 1;
        holdRes = bus.out_res;
        holdZero = bus.out_zero;
        holdPar = bus.out_par;
        holdErr = bus.out_err;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 32'(1), 32'(0));
        end else begin
          front = expQ.pop_front();
          checkOutput("sb_res", 32'(bus.out_res), 32'(front.res));
          checkOutput("sb_zero", 32'(bus.out_zero), 32'(front.zero));
          checkOutput("sb_par", 32'(bus.out_par), 32'(front.par));
          checkOutput("sb_err", 32'(bus.out_err), 32'(front.err));
        end
        modelCount++;
      end
      if (bus.in_valid && bus.in_ready)
        expQ.push_back(refModel(bus.in_a, bus.in_b, bus.in_op));
    end
  end

  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic idleInput();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_op    = '0;
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int c;
    idleInput();
    bus.out_ready = 1'b1;
    for (c = 0; c < 20 && expQ.size() != 0; c++) tick();
    tick();
    checkOutput("drain_empty", 32'(expQ.size()), 32'(0));
  endtask

  // Sends n beats (fixed pattern seeded by base), honouring in_ready.
  task automatic sendBeats(input int n, input logic [W-1:0] base);
    int sent = 0;
    for (int c = 0; c < 40 && sent < n; c++) begin
      applyStimulus(base + 8'(sent * 17), base ^ 8'(sent * 5), 3'(sent % 8));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    idleInput();
    checkOutput("beats_sent", 32'(sent), 32'(n));
  endtask

  logic [W-1:0] bpA [4];
  logic [W-1:0] bpB [4];
  logic [2:0]   bpOp [4];

  initial begin
    int sent;

    vecs[0]  = '{8'hF0, 8'h3C, 3'd0, 8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 8'h3C, 3'd1, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 8'h3C, 3'd2, 8'hCF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'hF0, 8'h3C, 3'd3, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 8'h3C, 3'd4, 8'hCC, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 8'h3C, 3'd5, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h01, 8'h00, 3'd0, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'hAA, 8'h00, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{8'h55, 8'h0F, 3'd6, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{8'h5A, 8'hFF, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h00, 8'h00, 3'd3, 8'hFF, 1'b0, 1'b0, 1'b0};

    bpA  = '{8'h11, 8'h33, 8'h55, 8'h77};
    bpB  = '{8'h22, 8'h44, 8'h66, 8'h88};
    bpOp = '{3'd0, 3'd2, 3'd4, 3'd7};

    idleInput();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(1));
    checkOutput("rst_op_count", 32'(bus.op_count), 32'(0));
    checkOutput("rst_out_res", 32'(bus.out_res), 32'(0));
    checkOutput("rst_flags", 32'({bus.out_zero, bus.out_par, bus.out_err}), 32'(0));
    tick();

    // Back-to-back table; entry c-2 is on the outputs during cycle c.
    bus.out_ready = 1'b1;
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) applyStimulus(vecs[c].a, vecs[c].b, vecs[c].op);
      else idleInput();
      @(negedge clk);
      if (c >= 2) begin
        checkOutput($sformatf("vec%0d_valid", c - 2), 32'(bus.out_valid), 32'(1));
        checkOutput($sformatf("vec%0d_res", c - 2), 32'(bus.out_res), 32'(vecs[c - 2].res));
        checkOutput($sformatf("vec%0d_zero", c - 2), 32'(bus.out_zero), 32'(vecs[c - 2].zero));
        checkOutput($sformatf("vec%0d_par", c - 2), 32'(bus.out_par), 32'(vecs[c - 2].par));
        checkOutput($sformatf("vec%0d_err", c - 2), 32'(bus.out_err), 32'(vecs[c - 2].err));
      end
      tick();
    end
    idleInput();
    @(negedge clk);
    checkOutput("vec_op_count", 32'(bus.op_count), 32'(NV));
    checkOutput("vec_drained", 32'(bus.out_valid), 32'(0));
    tick();

    // Backpressure: only two beats fit while the consumer stalls.
    bus.out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      if (sent < 4) applyStimulus(bpA[sent], bpB[sent], bpOp[sent]);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    @(negedge clk);
    checkOutput("bp_accepted", 32'(sent), 32'(2));
    checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'(0));
    checkOutput("bp_head_res", 32'(bus.out_res), 32'(bpA[0] | bpB[0]));
    tick();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      applyStimulus(bpA[sent], bpB[sent], bpOp[sent]);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    checkOutput("bp_all_sent", 32'(sent), 32'(4));
    drain();
    checkOutput("bp_op_count", 32'(bus.op_count), 32'(NV + 4));

    // Reset with both stages full must discard the in-flight beats.
    bus.out_ready = 1'b0;
    sendBeats(2, 8'h3A);
    @(negedge clk);
    checkOutput("full_before_rst", 32'(bus.out_valid), 32'(1));
    tick();
    resetPulse();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post_rst_no_beat", 32'(bus.out_valid), 32'(0));
      checkOutput("post_rst_count", 32'(bus.op_count), 32'(0));
      tick();
    end

    // Counter wrap on the CNT_W = 2 copy: five transfers leave it at 1.
    sendBeats(5, 8'hC3);
    drain();
    @(negedge clk);
    checkOutput("wrap_count_w2", 32'(bus2.op_count), 32'(1));
    checkOutput("wrap_count_w16", 32'(bus.op_count), 32'(5));
    tick();

    // Randomized traffic with random stalls.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) != 0)
        applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      else
        idleInput();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Two-stage pipelined bitwise logic unit built from the team's primitive gate family (OR, NOT, NAND, NOR, XOR, XNOR).
- Consumes operand pairs through a valid/ready handshake and produces registered results with status flags.
- Sits between an operand source, such as a register file or test-vector generator, and any downstream consumer.
- Full throughput of one operation per clock, with backpressure support.

Parameters:
- W, 8, operand and result width in bits (W >= 1)
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat this cycle
- in_a  input  W  operand A
- in_b  input  W  operand B (ignored for NOT)
- in_op  input  3  opcode: 0 OR, 1 NOT(A), 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- out_res  output  W  bitwise result
- out_zero  output  1  out_res == 0
- out_par  output  1  XOR-reduction of out_res
- out_err  output  1  beat carried a reserved opcode
- op_count  output  CNT_W  number of completed output transfers

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Transfers:
  - An input transfer occurs when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready at a rising edge.
- Stage 1 (S1):
  - Registers in_a, in_b, in_op and s1_valid on an input transfer.
- Stage 2 (S2):
  - Computes the op on the S1 contents and registers result, zero, par, err and s2_valid.
  - out_* are driven directly from S2 registers; there is no combinational path from in_* to out_*.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - On s2_adv, S2 loads S1 contents and s2_valid <= s1_valid.
  - On s1_adv, S1 loads input and s1_valid <= in_valid.
- Latency and throughput:
  - Latency is 2 cycles: a beat accepted at edge N appears with out_valid at edge N+2 when not stalled.
  - Sustained throughput is 1 beat/cycle while out_ready = 1.
- Backpressure:
  - While out_valid && !out_ready, out_res/out_zero/out_par/out_err hold stable.
  - When both stages are full and out_ready = 0, in_ready = 0 and input is not accepted.
  - No beat is dropped or duplicated.
- Reserved opcodes (6, 7):
  - Result is all zeros, out_zero = 1, out_par = 0, out_err = 1.
  - The beat still flows and is counted.
- op_count:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle are both honoured, so the pipeline stays full.
- Reset:
  - When rst = 1 at an edge, it overrides everything.
  - Reset values: s1_valid = 0, s2_valid = 0, out_valid = 0, out_res = 0, out_zero = 0, out_par = 0, out_err = 0, op_count = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards in-flight beats without producing output.
- Data registers of invalid stages are don't-care internally, but outputs must follow the reset values above until the first valid result.

Test Plan:
- Reset then idle → out_valid = 0, in_ready = 1, op_count = 0, out_res = 0.
- W = 8, stream A = 0xF0, B = 0x3C for ops 0–5 back-to-back, out_ready = 1 → results 0xFC, 0x0F, 0xCF, 0x03, 0xCC, 0x33 at edges N+2…N+7; par = 0,0,0,0,0,0; op_count = 6.
- A = 0xFF, B = 0xFF, op 4 → out_res = 0x00, out_zero = 1. A = 0x01, B = 0x00, op 0 → out_par = 1.
- Backpressure: send 4 beats, hold out_ready = 0 for 5 cycles → in_ready drops after 2 beats accepted, out_res stable; release → remaining beats delivered in order, none lost or repeated.
- op 7 with A = 0xAA → out_res = 0x00, out_err = 1, out_zero = 1, op_count increments.
- Assert rst with both stages full → next cycle out_valid = 0, op_count = 0, no stale beat emitted. Also preload op_count wrap with CNT_W = 2: 5 transfers → op_count = 1.
